// File: rtl/tmr_mem_scrubber_pkg.sv
// Shared types and constants for the TMR memory scrubber.
package scrub_pkg;

  localparam int unsigned CNT_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_INT,
    RD_REQ,
    RD_RESP,
    VOTE,
    WR_REQ
  } state_t;

endpackage

// File: rtl/tmr_mem_scrubber_voter.sv
// Combinational bitwise majority voter over three replicas, plus per-bit disagreement mask.
module tmr_voter #(
  parameter int unsigned DATA_W = 100
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] c,
  output logic [DATA_W-1:0] maj,
  output logic [DATA_W-1:0] mask
);

  always_comb begin
    maj  = (a & b) | (a & c) | (b & c);
    mask = (a ^ maj) | (b ^ maj) | (c ^ maj);
  end

endmodule

// File: rtl/tmr_mem_scrubber.sv
// Walks a triplicated memory word by word, votes the replicas, reports flipped bits
// on scrub_o and writes the voted word back when the replicas disagree.
module tmr_mem_scrubber
  import scrub_pkg::*;
#(
  parameter  int unsigned DATA_W   = 100,
  parameter  int unsigned DEPTH    = 1024,
  parameter  int unsigned INTERVAL = 16,
  localparam int unsigned ADDR_W   = $clog2(DEPTH)
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic                en_i,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  input  logic                mem_gnt_i,
  input  logic                mem_rvalid_i,
  input  logic [3*DATA_W-1:0] mem_rdata_i,
  output logic [DATA_W-1:0]   scrub_o,
  output logic                pass_done_o,
  output logic                busy_o,
  output logic [CNT_W-1:0]    corr_cnt_o
);

  localparam int unsigned IW = (INTERVAL > 0) ? $clog2(INTERVAL + 1) : 1;

  state_t                r_state;
  logic [ADDR_W-1:0]     r_addr;
  logic [IW-1:0]         r_cnt;
  logic [3*DATA_W-1:0]   r_rdata;
  logic [DATA_W-1:0]     r_wdata;
  logic [DATA_W-1:0]     r_scrub;
  logic                  r_pass_done;
  logic [CNT_W-1:0]      r_corr;

  logic [DATA_W-1:0]     w_maj;
  logic [DATA_W-1:0]     w_mask;
  logic                  w_wrap;
  logic [ADDR_W-1:0]     w_addr_nxt;
  state_t                w_adv_state;

  tmr_voter #(
    .DATA_W(DATA_W)
  ) u_voter (
    .a    (r_rdata[DATA_W-1:0]),
    .b    (r_rdata[2*DATA_W-1:DATA_W]),
    .c    (r_rdata[3*DATA_W-1:2*DATA_W]),
    .maj  (w_maj),
    .mask (w_mask)
  );

  // Where the walk continues once the current word is finished.
  always_comb begin
    w_wrap      = (r_addr == ADDR_W'(DEPTH - 1));
    w_addr_nxt  = w_wrap ? '0 : r_addr + 1'b1;
    w_adv_state = IDLE;
    if (en_i) w_adv_state = (INTERVAL == 0) ? RD_REQ : WAIT_INT;
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_cnt       <= '0;
      r_rdata     <= '0;
      r_wdata     <= '0;
      r_scrub     <= '0;
      r_pass_done <= 1'b0;
      r_corr      <= '0;
    end else begin
      r_scrub     <= '0;
      r_pass_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (en_i) begin
            r_state <= (INTERVAL == 0) ? RD_REQ : WAIT_INT;
            r_cnt   <= IW'(INTERVAL);
          end
        end
        WAIT_INT: begin
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt <= IW'(1)) r_state <= RD_REQ;
        end
        RD_REQ: begin
          if (mem_gnt_i) r_state <= RD_RESP;
        end
        RD_RESP: begin
          if (mem_rvalid_i) begin
            r_rdata <= mem_rdata_i;
            r_state <= VOTE;
          end
        end
        VOTE: begin
          r_scrub <= w_mask;
          if (|w_mask) begin
            r_wdata <= w_maj;
            r_state <= WR_REQ;
          end else begin
            r_addr      <= w_addr_nxt;
            r_pass_done <= w_wrap;
            r_cnt       <= IW'(INTERVAL);
            r_state     <= w_adv_state;
          end
        end
        WR_REQ: begin
          if (mem_gnt_i) begin
            if (r_corr != '1) r_corr <= r_corr + 1'b1;
            r_addr      <= w_addr_nxt;
            r_pass_done <= w_wrap;
            r_cnt       <= IW'(INTERVAL);
            r_state     <= w_adv_state;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    mem_req_o   = (r_state == RD_REQ) || (r_state == WR_REQ);
    mem_we_o    = (r_state == WR_REQ);
    mem_addr_o  = r_addr;
    mem_wdata_o = r_wdata;
    scrub_o     = r_scrub;
    pass_done_o = r_pass_done;
    busy_o      = (r_state != IDLE);
    corr_cnt_o  = r_corr;
  end

endmodule

// File: tb/tb_tmr_mem_scrubber.sv
// Bench for tmr_mem_scrubber: transaction-level reference model plus directed scenarios and random traffic.
module tb_tmr_mem_scrubber;

  localparam int unsigned DW       = 100;
  localparam int unsigned DEPTH    = 4;
  localparam int unsigned AW       = 2;
  localparam int unsigned INTERVAL = 2;

  logic            clk_i = 1'b0;
  logic            rstn_i;
  logic            en_i;
  logic            mem_req_o;
  logic            mem_we_o;
  logic [AW-1:0]   mem_addr_o;
  logic [DW-1:0]   mem_wdata_o;
  logic            mem_gnt_i;
  logic            mem_rvalid_i;
  logic [3*DW-1:0] mem_rdata_i;
  logic [DW-1:0]   scrub_o;
  logic            pass_done_o;
  logic            busy_o;
  logic [31:0]     corr_cnt_o;

  always #5 clk_i = ~clk_i;

  tmr_mem_scrubber #(.DATA_W(DW), .DEPTH(DEPTH), .INTERVAL(INTERVAL)) dut (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .en_i         (en_i),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .scrub_o      (scrub_o),
    .pass_done_o  (pass_done_o),
    .busy_o       (busy_o),
    .corr_cnt_o   (corr_cnt_o)
  );

  logic [DW-1:0] mem_a [DEPTH];
  logic [DW-1:0] mem_b [DEPTH];
  logic [DW-1:0] mem_c [DEPTH];

  int n_cmp = 0, n_bad = 0, cyc = 0;
  int unsigned rd_dly = 0, wr_dly = 0;
  bit rnd_rv = 1'b0;

  // reference model state
  int unsigned exp_addr = 0;
  bit idle_wait = 1'b1, resume_v = 1'b0;
  int resume_c = 0;
  bit rd_out = 1'b0;
  int rv_c = 0;
  int unsigned rd_addr = 0;
  bit exp_wr_v = 1'b0;
  int exp_wr_c = 0;
  logic [DW-1:0] exp_wr_d = '0;
  bit scr_v = 1'b0;
  int scr_c = 0;
  logic [DW-1:0] scr_m = '0;
  bit pd_v = 1'b0;
  int pd_c = 0;
  bit adv_v = 1'b0;
  int adv_c = 0;
  logic [31:0] corr = '0;
  bit post_rst = 1'b0, prev_req = 1'b0, prev_gnt = 1'b0, wr_active = 1'b0;
  bit g, new_txn;
  bit s_we = 1'b0;
  logic [AW-1:0] s_addr = '0;
  logic [DW-1:0] s_wdata = '0;
  int hold = 0, wcnt = 0;
  int rd_count = 0, wr_count = 0, pd_count = 0, last_rd_hold = 0, last_wr_hold = 0;
  int unsigned last_gnt_addr = 0;
  logic [DW-1:0] last_scrub = '0;
  logic [DW-1:0] mv, kv;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] rnd_word();
    logic [127:0] t;
    t = {$urandom, $urandom, $urandom, $urandom};
    return t[DW-1:0];
  endfunction

  // Per-bit vote by counting ones among the three replicas.
  function automatic void vote(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] c,
                               output logic [DW-1:0] m, output logic [DW-1:0] k);
    for (int i = 0; i < int'(DW); i++) begin
      int ones;
      ones = int'(a[i]) + int'(b[i]) + int'(c[i]);
      m[i] = (ones >= 2);
      k[i] = (ones == 1) || (ones == 2);
    end
  endfunction

  task automatic model_adv();
    if (exp_addr == DEPTH - 1) begin
      pd_v = 1'b1; pd_c = cyc + 1; exp_addr = 0;
    end else begin
      exp_addr++;
    end
    if (en_i) begin resume_v = 1'b1; resume_c = cyc; end
    else idle_wait = 1'b1;
  endtask

  // Memory model + per-cycle comparison, evaluated on the falling edge.
  initial begin
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    forever begin
      @(negedge clk_i);
      cyc++;
      g = 1'b0;
      mem_rvalid_i = 1'b0;
      mem_rdata_i = {rnd_word(), rnd_word(), rnd_word()};
      if (!rstn_i) begin
        exp_addr = 0; idle_wait = 1'b1; resume_v = 1'b0; rd_out = 1'b0; exp_wr_v = 1'b0;
        scr_v = 1'b0; pd_v = 1'b0; adv_v = 1'b0; corr = '0; post_rst = 1'b1;
        prev_req = 1'b0; wr_active = 1'b0;
      end else begin
        chk("busy", busy_o, !idle_wait);
        chk("scrub", scrub_o, (scr_v && scr_c == cyc) ? scr_m : '0);
        if (scr_v && cyc >= scr_c) scr_v = 1'b0;
        chk("pass_done", pass_done_o, pd_v && pd_c == cyc);
        if (pd_v && cyc >= pd_c) pd_v = 1'b0;
        chk("corr_cnt", corr_cnt_o, corr);
        if (scrub_o != '0) last_scrub = scrub_o;
        if (pass_done_o) pd_count++;
        if (post_rst) begin
          chk("rst_req", mem_req_o, 0);
          chk("rst_we", mem_we_o, 0);
          chk("rst_addr", mem_addr_o, 0);
          chk("rst_wdata", mem_wdata_o, 0);
          post_rst = 1'b0;
        end
        if (idle_wait && en_i) begin
          idle_wait = 1'b0; resume_v = 1'b1; resume_c = cyc;
        end
        if (adv_v && adv_c == cyc) begin
          adv_v = 1'b0;
          model_adv();
        end
        if (rd_out && rv_c == cyc) begin
          rd_out = 1'b0;
          mem_rvalid_i = 1'b1;
          mem_rdata_i = {mem_c[rd_addr], mem_b[rd_addr], mem_a[rd_addr]};
          vote(mem_a[rd_addr], mem_b[rd_addr], mem_c[rd_addr], mv, kv);
          scr_v = 1'b1; scr_c = cyc + 2; scr_m = kv;
          if (kv != '0) begin
            exp_wr_v = 1'b1; exp_wr_c = cyc + 2; exp_wr_d = mv;
          end else begin
            adv_v = 1'b1; adv_c = cyc + 1;
          end
        end else if (!rd_out && $urandom_range(3, 0) == 0) begin
          mem_rvalid_i = 1'b1;
        end
        new_txn = mem_req_o && (!prev_req || prev_gnt);
        if (new_txn) begin
          s_we = mem_we_o; s_addr = mem_addr_o; s_wdata = mem_wdata_o; hold = 1;
          wcnt = mem_we_o ? int'(wr_dly) : int'(rd_dly);
          chk("txn_addr", mem_addr_o, exp_addr);
          if (!mem_we_o) begin
            chk("rd_start_cycle", cyc, resume_v ? resume_c + int'(INTERVAL) + 1 : 0);
            chk("rd_while_wr_due", exp_wr_v, 0);
            resume_v = 1'b0;
          end else begin
            chk("wr_expected", exp_wr_v, 1);
            chk("wr_start_cycle", cyc, exp_wr_c);
            chk("wr_data", mem_wdata_o, exp_wr_d);
          end
        end else if (mem_req_o) begin
          hold++;
          chk("hold_we", mem_we_o, s_we);
          chk("hold_addr", mem_addr_o, s_addr);
          chk("hold_wdata", mem_wdata_o, s_wdata);
        end
        if (mem_req_o) begin
          if (wcnt == 0) g = 1'b1;
          else wcnt--;
        end
        wr_active = mem_req_o && mem_we_o;
        if (g) begin
          if (mem_we_o) begin
            last_wr_hold = hold; wr_count++;
            mem_a[mem_addr_o] = mem_wdata_o;
            mem_b[mem_addr_o] = mem_wdata_o;
            mem_c[mem_addr_o] = mem_wdata_o;
            if (corr != 32'hFFFF_FFFF) corr++;
            exp_wr_v = 1'b0;
            model_adv();
          end else begin
            last_rd_hold = hold; rd_count++; last_gnt_addr = mem_addr_o;
            rd_addr = mem_addr_o; rd_out = 1'b1;
            rv_c = cyc + (rnd_rv ? int'($urandom_range(3, 1)) : 1);
          end
        end
        prev_req = mem_req_o;
      end
      prev_gnt = g;
      mem_gnt_i = g;
    end
  end

  function automatic int sel(input int w);
    case (w)
      0: return wr_count;
      1: return pd_count;
      2: return rd_count;
      default: return int'(wr_active);
    endcase
  endfunction

  task automatic wait_for(input string nm, input int w, input int target);
    int k;
    k = 0;
    while (sel(w) < target && k < 400) begin
      @(posedge clk_i);
      k++;
    end
    #2;
    chk({nm, "_reached"}, 128'(sel(w) >= target), 1);
  endtask

  initial begin
    logic [DW-1:0] w, orig, e;
    int base, a5;
    rstn_i = 1'b0; en_i = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      w = rnd_word(); mem_a[i] = w; mem_b[i] = w; mem_c[i] = w;
    end
    repeat (2) @(posedge clk_i);
    #2 rstn_i = 1'b1; en_i = 1'b1;

    // clean pass
    wait_for("pass1", 1, 1);
    chk("pass1_reads", rd_count, 4);
    chk("pass1_writes", wr_count, 0);
    chk("pass1_scrub", last_scrub, 0);

    // single flip in replica b, addr 2, bit 5
    orig = mem_a[2];
    mem_b[2][5] = ~mem_b[2][5];
    wait_for("s2_wb", 0, 1);
    e = '0; e[5] = 1'b1;
    chk("s2_mask", last_scrub, e);
    chk("s2_restored", mem_b[2], orig);
    chk("s2_corr", corr_cnt_o, 1);
    base = pd_count;
    wait_for("s2_clean", 1, base + 2);
    chk("s2_one_write", wr_count, 1);

    // two flips in different replicas of addr 1
    mem_a[1][0]  = ~mem_a[1][0];
    mem_c[1][99] = ~mem_c[1][99];
    wait_for("s3_wb", 0, 2);
    e = '0; e[0] = 1'b1; e[99] = 1'b1;
    chk("s3_mask", last_scrub, e);
    chk("s3_popcount", $countones(last_scrub), 2);
    chk("s3_restored", mem_a[1], mem_c[1]);

    // delayed grants on read and write
    rd_dly = 3; wr_dly = 3;
    mem_c[3][50] = ~mem_c[3][50];
    wait_for("s4_wb", 0, 3);
    chk("s4_rd_hold", last_rd_hold, 4);
    chk("s4_wr_hold", last_wr_hold, 4);
    rd_dly = 0; wr_dly = 0;

    // enable dropped while the read response is pending
    base = rd_count;
    wait_for("s5_rd", 2, base + 1);
    a5 = int'(last_gnt_addr);
    mem_b[a5][7] = ~mem_b[a5][7];
    en_i = 1'b0;
    base = wr_count;
    wait_for("s5_wb", 0, base + 1);
    repeat (8) @(posedge clk_i);
    #2;
    chk("s5_idle_busy", busy_o, 0);
    chk("s5_idle_req", mem_req_o, 0);
    base = rd_count;
    en_i = 1'b1;
    wait_for("s5_resume", 2, base + 1);
    chk("s5_resume_addr", last_gnt_addr, (a5 + 1) % int'(DEPTH));

    // reset during a stalled write-back
    wr_dly = 6;
    base = rd_count;
    wait_for("s6_rd", 2, base + 1);
    mem_a[last_gnt_addr][33] = ~mem_a[last_gnt_addr][33];
    wait_for("s6_wr", 3, 1);
    rstn_i = 1'b0;
    @(posedge clk_i);
    #2 rstn_i = 1'b1;
    wr_dly = 0;
    chk("s6_req", mem_req_o, 0);
    chk("s6_scrub", scrub_o, 0);
    chk("s6_addr", mem_addr_o, 0);
    chk("s6_corr", corr_cnt_o, 0);

    // randomized traffic
    rnd_rv = 1'b1;
    for (int i = 0; i < 600; i++) begin
      @(posedge clk_i);
      #2;
      rd_dly = $urandom_range(3, 0);
      wr_dly = $urandom_range(3, 0);
      if ($urandom_range(30, 0) == 0) begin
        int unsigned ad, bt, rp;
        ad = $urandom_range(DEPTH - 1, 0); bt = $urandom_range(DW - 1, 0); rp = $urandom_range(2, 0);
        if (rp == 0) mem_a[ad][bt] = ~mem_a[ad][bt];
        else if (rp == 1) mem_b[ad][bt] = ~mem_b[ad][bt];
        else mem_c[ad][bt] = ~mem_c[ad][bt];
      end
      if ($urandom_range(50, 0) == 0) en_i = ~en_i;
      if (!rstn_i) rstn_i = 1'b1;
      else if ($urandom_range(250, 0) == 0) rstn_i = 1'b0;
    end
    rstn_i = 1'b1; en_i = 1'b1;
    base = pd_count;
    wait_for("final_passes", 1, base + 2);
    en_i = 1'b0;
    repeat (30) @(posedge clk_i);
    #2;
    chk("final_idle", busy_o, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
